// File: rtl/seq_pkg.sv
// Shared types and opcode constants for the program-counter sequencer.
// Flow-control opcodes live in the top nibble of the instruction word.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_BRZ  = 4'hB;
  localparam logic [3:0] OP_CALL = 4'hD;
  localparam logic [3:0] OP_RET  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack for CALL/RET: a depth counter over a small register file.
// Only the pointer is reset; stale entries are harmless because empty/full gate every access.
module ret_stack #(
  parameter int AW          = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] din,
  output logic [AW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int CW = $clog2(STACK_DEPTH + 1);
  localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [CW-1:0] r_count;
  logic [AW-1:0] r_mem [STACK_DEPTH];
  logic [PW-1:0] w_wr_idx;
  logic [PW-1:0] w_rd_idx;

  assign w_wr_idx = r_count[PW-1:0];
  // Top-of-stack sits one below the write slot; modular PW-bit math is exact here.
  assign w_rd_idx = w_wr_idx - PW'(1);
  assign full     = (r_count == CW'(STACK_DEPTH));
  assign empty    = (r_count == '0);
  assign dout     = r_mem[w_rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (push && !full) begin
      r_count <= r_count + CW'(1);
    end else if (pop && !empty) begin
      r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      r_mem[w_wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/decode/dispatch controller that solely drives the program counter.
// Flow control (JMP/BRZ/CALL/RET/HALT) is resolved here; everything else goes to execute.
module pc_sequencer
  import seq_pkg::*;
#(
  parameter int AW          = 8,
  parameter int IW          = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          halt_req,
  input  logic          zero_flag,
  input  logic [AW-1:0] pc_addr,
  output logic          pc_inc,
  output logic          pc_jmp,
  output logic [AW-1:0] pc_target,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [IW-1:0] imem_data,
  output logic          instr_valid,
  output logic [IW-1:0] instr_out,
  input  logic          exec_done,
  output logic          halted,
  output logic          fault
);

  state_t        r_state;
  state_t        w_state_next;
  state_t        w_fetch_or_halt;
  logic [IW-1:0] r_ir;
  logic [3:0]    w_opcode;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_ret_addr;
  logic [AW-1:0] w_ret_top;
  logic          w_push;
  logic          w_pop;
  logic          w_full;
  logic          w_empty;

  assign w_opcode   = r_ir[IW-1 -: 4];
  assign w_target   = r_ir[AW-1:0];
  assign w_ret_addr = pc_addr + AW'(1);
  // Every instruction boundary is a potential stop point.
  assign w_fetch_or_halt = halt_req ? HALTED : FETCH;

  ret_stack #(
    .AW          (AW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_ret_addr),
    .dout  (w_ret_top),
    .full  (w_full),
    .empty (w_empty)
  );

  always_comb begin
    w_state_next = r_state;
    pc_inc       = 1'b0;
    pc_jmp       = 1'b0;
    pc_target    = '0;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    case (r_state)
      IDLE:   if (run) w_state_next = w_fetch_or_halt;
      FETCH:  if (imem_ack) w_state_next = DECODE;
      DECODE: begin
        case (w_opcode)
          OP_JMP: begin
            pc_jmp       = 1'b1;
            pc_target    = w_target;
            w_state_next = w_fetch_or_halt;
          end
          OP_BRZ: begin
            pc_jmp       = zero_flag;
            pc_inc       = !zero_flag;
            pc_target    = zero_flag ? w_target : '0;
            w_state_next = w_fetch_or_halt;
          end
          OP_CALL: begin
            if (w_full) begin
              w_state_next = FAULT;
            end else begin
              w_push       = 1'b1;
              pc_jmp       = 1'b1;
              pc_target    = w_target;
              w_state_next = w_fetch_or_halt;
            end
          end
          OP_RET: begin
            if (w_empty) begin
              w_state_next = FAULT;
            end else begin
              w_pop        = 1'b1;
              pc_jmp       = 1'b1;
              pc_target    = w_ret_top;
              w_state_next = w_fetch_or_halt;
            end
          end
          OP_HALT: w_state_next = HALTED;
          default: begin
            pc_inc       = 1'b1;
            w_state_next = EXEC;
          end
        endcase
      end
      EXEC:   if (exec_done) w_state_next = w_fetch_or_halt;
      HALTED: if (run && !halt_req) w_state_next = FETCH;
      FAULT:  w_state_next = FAULT;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == FETCH && imem_ack) begin
        r_ir <= imem_data;
      end
    end
  end

  // Moore-style requests so an asynchronous reset drops them immediately.
  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = imem_req ? pc_addr : '0;
  assign instr_valid = (r_state == EXEC);
  assign instr_out   = r_ir;
  assign halted      = (r_state == HALTED);
  assign fault       = (r_state == FAULT);

endmodule
